// File: rtl/joypad_pkg.sv
// Shared constants and types for the joypad debounce front end.
package joypad_pkg;

   // Number of physical button pins handled by the front end.
   localparam int unsigned NUM_BUTTONS = 8;

   // Bit positions within the active-low button vector.
   localparam int unsigned BTN_RIGHT  = 0;
   localparam int unsigned BTN_LEFT   = 1;
   localparam int unsigned BTN_UP     = 2;
   localparam int unsigned BTN_DOWN   = 3;
   localparam int unsigned BTN_A      = 4;
   localparam int unsigned BTN_B      = 5;
   localparam int unsigned BTN_SELECT = 6;
   localparam int unsigned BTN_START  = 7;

   // Per-pin debounce FSM: IDLE while the synchronized pin matches the
   // accepted level, COUNT while a differing level is being qualified.
   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } db_state_e;

endpackage : joypad_pkg

// File: rtl/debounce_bit.sv
// One pin: synchronizer chain, stability counter and accept FSM.
module debounce_bit
   import joypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iRaw,
   output logic oLevel,
   output logic oFall
);

   localparam int unsigned   CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   db_state_e              state_q;
   logic [CW-1:0]          cnt_q;
   logic                   level_q;
   logic                   fall_d;

   // Shift the raw pin through the synchronizer; released (1) out of reset.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], iRaw};
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Qualify a changed level for DEBOUNCE_CYCLES consecutive cycles before accepting it.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (sync_s != level_q) begin
                  state_q <= COUNT;
                  cnt_q   <= CW'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            COUNT: begin
               if (sync_s == level_q) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == C_LAST) begin
                  level_q <= sync_s;
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Fall is flagged in the cycle the 1->0 accept is decided, so a register
   // downstream lines its pulse up with the cycle oLevel first shows 0.
   always_comb begin
      fall_d = 1'b0;
      if (state_q == COUNT && sync_s != level_q && cnt_q == C_LAST && level_q) begin
         fall_d = 1'b1;
      end
   end

   assign oLevel = level_q;
   assign oFall  = fall_d;

endmodule : debounce_bit

// File: rtl/joypad_debounce.sv
// Joypad front end: per-pin debounce plus a merged press strobe.
module joypad_debounce
   import joypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [NUM_BUTTONS-1:0] iButtons,
   output logic [NUM_BUTTONS-1:0] oButtons,
   output logic                   oPressStrobe
);

   logic [NUM_BUTTONS-1:0] fall;
   logic                   strobe_q;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_bit (
         .Clock (Clock),
         .Reset (Reset),
         .iRaw  (iButtons[i]),
         .oLevel(oButtons[i]),
         .oFall (fall[i])
      );
   end

   // Any accepted press in a cycle yields one strobe, coincident with oButtons.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= |fall;
      end
   end

   assign oPressStrobe = strobe_q;

endmodule : joypad_debounce

// File: tb/tb_joypad_debounce.sv
// Scoreboard bench for joypad_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_joypad_debounce;

   // Input driven at a negedge with cycle counter n: first sampling edge is
   // n+1, output appears after edge n+6 and is seen at the negedge where cyc==n+6.
   localparam int unsigned LAT = 6;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  btn;
      logic        stb;
   } exp_t;

   logic       Clock;
   logic       Reset;
   logic [7:0] iButtons;
   logic [7:0] oButtons;
   logic       oPressStrobe;

   exp_t        exp_q[$];
   int unsigned cyc;
   int          checks;
   int          errors;
   logic [7:0]  prev_btn;
   logic        prev_stb;
   logic        done;

   joypad_debounce #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iButtons    (iButtons),
      .oButtons    (oButtons),
      .oPressStrobe(oPressStrobe)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Expect a press: new vector with strobe, then strobe drop one cycle later.
   task automatic expect_press(input int unsigned n, input logic [7:0] v);
      exp_t e;
      e.cyc = n + LAT;     e.btn = v; e.stb = 1'b1; exp_q.push_back(e);
      e.cyc = n + LAT + 1; e.btn = v; e.stb = 1'b0; exp_q.push_back(e);
   endtask

   task automatic expect_release(input int unsigned n, input logic [7:0] v);
      exp_t e;
      e.cyc = n + LAT; e.btn = v; e.stb = 1'b0; exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (oButtons !== 8'hFF || oPressStrobe !== 1'b0) begin
         errors++;
         $display("FAIL %s: got btn=%h stb=%b, want btn=ff stb=0", name, oButtons, oPressStrobe);
      end
   endtask

   task automatic wait_cycles(input int unsigned k);
      repeat (k) @(negedge Clock);
   endtask

   // Monitor: every change of the outputs while out of reset must match the next expected event.
   always @(negedge Clock) begin
      if (Reset === 1'b1 && !done &&
          (oButtons !== prev_btn || oPressStrobe !== prev_stb)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got btn=%h stb=%b at cyc=%0d, want no change",
                     oButtons, oPressStrobe, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (oButtons !== e.btn || oPressStrobe !== e.stb || cyc != e.cyc) begin
               errors++;
               $display("FAIL output_event: got btn=%h stb=%b cyc=%0d, want btn=%h stb=%b cyc=%0d",
                        oButtons, oPressStrobe, cyc, e.btn, e.stb, e.cyc);
            end
         end
      end
      prev_btn <= oButtons;
      prev_stb <= oPressStrobe;
   end

   initial begin
      int unsigned n;
      logic [7:0]  v;
      checks   = 0;
      errors   = 0;
      done     = 1'b0;
      cyc      = 0;
      prev_btn = 8'hFF;
      prev_stb = 1'b0;
      Reset    = 1'b0;
      iButtons = 8'h00;

      // Reset holds outputs at released values despite all pins low.
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         check_reset_outputs("reset_hold");
      end
      iButtons = 8'hFF;
      wait_cycles(3);
      Reset = 1'b1;
      wait_cycles(4);

      // Single press of A, then release.
      n = cyc; iButtons = 8'hEF; expect_press(n, 8'hEF);
      wait_cycles(10);
      n = cyc; iButtons = 8'hFF; expect_release(n, 8'hFF);
      wait_cycles(10);

      // B glitch of 3 cycles is shorter than the debounce window.
      iButtons = 8'hDF;
      wait_cycles(3);
      iButtons = 8'hFF;
      wait_cycles(10);

      // UP+DOWN together: one update, one strobe; release has no strobe.
      n = cyc; iButtons = 8'hF3; expect_press(n, 8'hF3);
      wait_cycles(10);
      n = cyc; iButtons = 8'hFF; expect_release(n, 8'hFF);
      wait_cycles(10);

      // START held low, reset mid-count, then debounced from scratch.
      iButtons = 8'h7F;
      wait_cycles(3);
      #2 Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check_reset_outputs("reset_midcount");
      end
      n = cyc; Reset = 1'b1; expect_press(n, 8'h7F);
      wait_cycles(10);
      n = cyc; iButtons = 8'hFF; expect_release(n, 8'hFF);
      wait_cycles(10);

      // LEFT held low while RIGHT toggles every cycle.
      n = cyc; expect_press(n, 8'hFD);
      v = 8'hFD;
      for (int i = 0; i < 12; i++) begin
         iButtons = v;
         v[0] = ~v[0];
         @(negedge Clock);
      end
      n = cyc; iButtons = 8'hFF; expect_release(n, 8'hFF);
      wait_cycles(12);

      done = 1'b1;
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got no change, want btn=%h stb=%b at cyc=%0d",
                  e.btn, e.stb, e.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_joypad_debounce

// File: doc/joypad_debounce.md
# joypad_debounce

Upstream front end of the GameBoy joypad I/O stage. Takes the eight raw, asynchronous, active-low button pins from the board. Synchronizes and debounces each pin independently, then presents a clean, glitch-free active-low button vector to the `io` joypad stage. It also emits a one-cycle press strobe that the `io` stage uses as the joypad interrupt source.

## Interface

One clock; reset is asynchronous and active-low (`Reset` asserted = 0).

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized cycles required to accept a new level. Legal range is ≥2.
- `SYNC_STAGES`, default 2: flip-flop stages in each pin synchronizer. Legal range is ≥2.

Ports:
- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `iButtons`  in  8  raw pins, active-low (0 = pressed). Bit map: 7 START, 6 SELECT, 5 B, 4 A, 3 DOWN, 2 UP, 1 LEFT, 0 RIGHT.
- `oButtons`  out  8  debounced vector, active-low, same bit map.
- `oPressStrobe`  out  1  one-cycle pulse when any `oButtons` bit transitions 1→0.

## Operation

- Per bit, the synchronizer chain resets to 1 (released). Its last stage gives synchronized value `s`.
- Per bit, the accepted level `d` drives `oButtons[i]`. Each bit has a counter `c` of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Per-bit FSM has two states, IDLE and COUNT:
  - IDLE, `s == d`: stay; `c = 0`.
  - IDLE, `s != d`: go to COUNT; `c = 1`.
  - COUNT, `s == d`: abort. Go to IDLE, `c = 0`, `d` unchanged.
  - COUNT, `s != d`, `c < DEBOUNCE_CYCLES-1`: `c++`.
  - COUNT, `s != d`, `c == DEBOUNCE_CYCLES-1`: `d <= s`, go to IDLE, `c = 0`.
- Press strobe: `oPressStrobe` is registered. It is 1 in exactly the cycle where at least one bit's `d` has just gone 1→0.
  - Multiple simultaneous presses produce one pulse.
  - Releases (0→1) never strobe.
  - A press on one bit and a release on another in the same cycle does strobe.
- Bits are fully independent. A glitch on one bit does not affect another bit's counter.
- A glitch held for fewer than `DEBOUNCE_CYCLES` synchronized cycles never reaches `oButtons`.

## Timing

- Reset values: `oButtons = 8'hFF`, `oPressStrobe = 0`, all synchronizer flops 1, all counters 0, all FSMs IDLE. These hold while `Reset = 0`, regardless of `iButtons`.
- Latency: let the first stage sample a new stable pin level at edge E. Then `oButtons` updates after edge E + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1.
  - The default parameters give 17 edges after E.
  - `oPressStrobe` is high for the same single cycle in which `oButtons` first shows the new 0.
- Throughput: a bit that has just accepted a level can begin counting a reverse change on the next cycle.
- Reset asserted mid-count: counters clear immediately (asynchronous). No strobe is emitted; outputs return to reset values.
- After deassertion, a pin held low throughout reset is debounced from scratch. It produces a strobe once accepted.
- `Reset` deassertion is synchronized externally; this block does not re-synchronize it.

## Structure

- Package `joypad_pkg`:
  - `NUM_BUTTONS = 8`.
  - Bit index constants `BTN_RIGHT = 0` … `BTN_START = 7`.
  - Per-bit FSM state enum {IDLE, COUNT}.
- Sub-module `debounce_bit`: one synchronizer, one counter and one FSM. It has ports `Clock`, `Reset`, `iRaw`, `oLevel`, `oFall` (1-cycle pulse on accepted 1→0).
- Top level instantiates `NUM_BUTTONS` of `debounce_bit` in a generate loop. It OR-reduces the `oFall` outputs into the registered `oPressStrobe`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES = 4` and `SYNC_STAGES = 2`.

- **Reset:** hold `Reset = 0` with `iButtons = 8'h00` → `oButtons = 8'hFF`, `oPressStrobe = 0` throughout.
- **Single press:** drive `iButtons = 8'hEF` (A) and hold → `oButtons = 8'hEF` after edge E+5. `oPressStrobe` is 1 for exactly that one cycle.
- **Glitch rejection:** pulse B low (`8'hDF`) for 3 cycles, then return to `8'hFF` → `oButtons` stays `8'hFF` and `oPressStrobe` stays 0.
- **Simultaneous press:** drive UP+DOWN (`8'hF3`) at the same edge → `oButtons = 8'hF3` in one update and a single `oPressStrobe` pulse. Then release to `8'hFF` → `oButtons = 8'hFF` after E+5 with no strobe.
- **Reset mid-count:** hold START low (`8'h7F`) for 3 cycles, assert `Reset`, then deassert with the pin still low → no strobe during reset. `oButtons = 8'h7F` with one strobe 5 edges after the first post-reset sampling edge.
- **Bit independence:** hold LEFT low steadily while toggling RIGHT every cycle → LEFT is accepted on schedule (`8'hFD`) and RIGHT never changes `oButtons[0]`.
